// File: rtl/bcd_xs3_serial_codec_pkg.sv
// rtl/bcd_xs3_serial_codec_pkg.sv - shared constants, state type and code checks for the BCD/XS-3 codec
// Ports: none (package bcd_xs3_pkg).
package bcd_xs3_pkg;

  localparam logic MODE_BCD2XS3 = 1'b0;
  localparam logic MODE_XS32BCD = 1'b1;

  localparam logic [3:0] K_BCD2XS3 = 4'b0011;  // +3
  localparam logic [3:0] K_XS32BCD = 4'b1101;  // -3 mod 16

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic [3:0] addend(input logic mode);
    return (mode == MODE_XS32BCD) ? K_XS32BCD : K_BCD2XS3;
  endfunction

  // BCD inputs must be 0..9; Excess-3 inputs must be 3..12.
  function automatic logic is_invalid(input logic mode, input logic [3:0] value);
    if (mode == MODE_XS32BCD)
      return (value < 4'd3) || (value > 4'd12);
    else
      return value > 4'd9;
  endfunction

endpackage

// File: rtl/bcd_xs3_serial_codec_if.sv
// rtl/bcd_xs3_serial_codec_if.sv - serial link bundle between front end and codec
// Signals: mode, sync, B_in, in_valid (towards codec); B_out, out_valid,
//          digit_done, digit_err, frame_done, frame_err (from codec).
// Modports: master = link driver / bench, slave = codec.
interface bcd_xs3_serial_codec_if;

  logic mode;
  logic sync;
  logic B_in;
  logic in_valid;
  logic B_out;
  logic out_valid;
  logic digit_done;
  logic digit_err;
  logic frame_done;
  logic frame_err;

  modport master (
    output mode, sync, B_in, in_valid,
    input  B_out, out_valid, digit_done, digit_err, frame_done, frame_err
  );

  modport slave (
    input  mode, sync, B_in, in_valid,
    output B_out, out_valid, digit_done, digit_err, frame_done, frame_err
  );

endinterface

// File: rtl/bcd_xs3_serial_codec_adder.sv
// rtl/bcd_xs3_serial_codec_adder.sv - 1-bit serial adder of a constant with registered sum
// Ports: clk, reset_b (async active-low), en (valid beat), clr (first bit of a digit,
//        carry-in forced to 0), a (data bit), k_bit (constant bit),
//        sum (registered result bit, 0 when idle), sum_valid (registered en).
module serial_const_adder (
  input  logic clk,
  input  logic reset_b,
  input  logic en,
  input  logic clr,
  input  logic a,
  input  logic k_bit,
  output logic sum,
  output logic sum_valid
);

  logic carry;
  logic c_in;

  // Carry out of bit 3 is dropped: clearing at the next digit's bit 0 gives mod-16.
  assign c_in = clr ? 1'b0 : carry;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      carry     <= 1'b0;
      sum       <= 1'b0;
      sum_valid <= 1'b0;
    end else begin
      sum_valid <= en;
      if (en) begin
        sum   <= a ^ k_bit ^ c_in;
        carry <= (a & k_bit) | (a & c_in) | (k_bit & c_in);
      end else begin
        sum <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/bcd_xs3_serial_codec.sv
// rtl/bcd_xs3_serial_codec.sv - bit-serial multi-digit BCD <-> Excess-3 converter
// Ports: clk (rising edge), reset_b (async active-low), bus (slave modport):
//        mode/sync/B_in/in_valid in; B_out/out_valid, digit_done, digit_err,
//        frame_done (1-cycle pulses on bit-3 output beat), frame_err (sticky per frame) out.
module bcd_xs3_serial_codec
  import bcd_xs3_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic                   clk,
  input  logic                   reset_b,
  bcd_xs3_serial_codec_if.slave  bus
);

  localparam int DCNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DCNT_W-1:0] LAST_DIGIT = DCNT_W'(NUM_DIGITS - 1);

  state_t              state, state_n;
  logic [1:0]          bit_cnt, bit_cnt_n;
  logic [DCNT_W-1:0]   digit_cnt, digit_cnt_n;
  logic                mode_r, mode_r_n;
  logic [2:0]          sr, sr_n;

  logic                beat;
  logic [1:0]          bit_idx;
  logic                mode_eff;
  logic                last_bit;
  logic                last_digit;
  logic                bad_code;
  logic [3:0]          k_vec;
  logic [3:0]          digit_val;

  logic                digit_done_r;
  logic                digit_err_r;
  logic                frame_done_r;
  logic                frame_err_r;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      digit_cnt <= '0;
      mode_r    <= 1'b0;
      sr        <= '0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      digit_cnt <= digit_cnt_n;
      mode_r    <= mode_r_n;
      sr        <= sr_n;
    end
  end

  always_comb begin
    // A sync beat is bit 0 of digit 0 in both states, so it overrides the
    // counters and the latched mode for this very beat.
    beat       = bus.in_valid && (bus.sync || state == RUN);
    bit_idx    = bus.sync ? 2'd0 : bit_cnt;
    mode_eff   = bus.sync ? bus.mode : mode_r;
    last_bit   = beat && (bit_idx == 2'd3);
    last_digit = (digit_cnt == LAST_DIGIT);
    k_vec      = addend(mode_eff);
    digit_val  = {bus.B_in, sr};
    bad_code   = is_invalid(mode_eff, digit_val);

    state_n     = state;
    bit_cnt_n   = bit_cnt;
    digit_cnt_n = digit_cnt;
    mode_r_n    = mode_r;
    sr_n        = sr;

    if (beat) begin
      mode_r_n = mode_eff;
      sr_n     = {bus.B_in, sr[2:1]};
      if (bit_idx == 2'd3) begin
        bit_cnt_n = 2'd0;
        if (last_digit) begin
          state_n     = IDLE;
          digit_cnt_n = '0;
        end else begin
          state_n     = RUN;
          digit_cnt_n = digit_cnt + 1'b1;
        end
      end else begin
        state_n     = RUN;
        bit_cnt_n   = bit_idx + 2'd1;
        digit_cnt_n = bus.sync ? '0 : digit_cnt;
      end
    end
  end

  serial_const_adder u_adder (
    .clk       (clk),
    .reset_b   (reset_b),
    .en        (beat),
    .clr       (bit_idx == 2'd0),
    .a         (bus.B_in),
    .k_bit     (k_vec[bit_idx]),
    .sum       (bus.B_out),
    .sum_valid (bus.out_valid)
  );

  // Flags are registered alongside the adder so they line up with the bit-3 output beat.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      digit_done_r <= 1'b0;
      digit_err_r  <= 1'b0;
      frame_done_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      digit_done_r <= last_bit;
      digit_err_r  <= last_bit && bad_code;
      frame_done_r <= last_bit && last_digit;
      if (beat && bus.sync)
        frame_err_r <= 1'b0;
      else if (last_bit && bad_code)
        frame_err_r <= 1'b1;
    end
  end

  assign bus.digit_done = digit_done_r;
  assign bus.digit_err  = digit_err_r;
  assign bus.frame_done = frame_done_r;
  assign bus.frame_err  = frame_err_r;

endmodule

// File: tb/tb_bcd_xs3_serial_codec.sv
// tb/tb_bcd_xs3_serial_codec.sv - self-checking bench for bcd_xs3_serial_codec
module tb_bcd_xs3_serial_codec;

  localparam int ND = 4;
  localparam int NB = ND * 4;

  logic clk = 1'b0;
  logic reset_b;

  bcd_xs3_serial_codec_if bus ();

  bcd_xs3_serial_codec #(.NUM_DIGITS(ND)) dut (
    .clk     (clk),
    .reset_b (reset_b),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic o_valid, o_bit, o_dd, o_de, o_fd, o_fe;

  logic [3:0] in_d  [ND];
  logic [3:0] out_d [ND];
  logic       out_e [ND];
  int         fd_cnt, dd_bad, lat_bad;
  logic       fd_last, fe_first, fe_end;

  // Reference: +3 / -3 modulo 16 and the legal-code ranges of each code.
  function automatic logic [3:0] exp_digit(input logic m, input logic [3:0] d);
    int r;
    r = m ? (int'(d) - 3 + 16) % 16 : (int'(d) + 3) % 16;
    return 4'(r);
  endfunction

  function automatic logic exp_err(input logic m, input logic [3:0] d);
    if (m) return (d < 3) || (d > 12);
    return d > 9;
  endfunction

  task automatic step(input logic v, input logic s, input logic b, input logic m);
    bus.in_valid = v;
    bus.sync     = s;
    bus.B_in     = b;
    bus.mode     = m;
    @(posedge clk);
    #1;
    o_valid = bus.out_valid;
    o_bit   = bus.B_out;
    o_dd    = bus.digit_done;
    o_de    = bus.digit_err;
    o_fd    = bus.frame_done;
    o_fe    = bus.frame_err;
    @(negedge clk);
  endtask

  // Sends nbeats bits of in_d (sync on the first), with random idle gaps,
  // and collects what came back on each beat.
  task automatic run_frame(input logic m, input int nbeats, input int max_gap, input bit toggle);
    int g, d, b;
    logic mm;
    fd_cnt = 0; dd_bad = 0; lat_bad = 0; fd_last = 0; fe_first = 0;
    for (int i = 0; i < ND; i++) begin
      out_d[i] = '0;
      out_e[i] = 1'b0;
    end
    for (int n = 0; n < nbeats; n++) begin
      g = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
      for (int j = 0; j < g; j++) begin
        step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
        if (o_valid || o_dd || o_de || o_fd) lat_bad++;
      end
      d  = n / 4;
      b  = n % 4;
      mm = (n == 0 || !toggle) ? m : 1'($urandom);
      step(1'b1, n == 0, in_d[d][b], mm);
      if (o_valid !== 1'b1) lat_bad++;
      out_d[d][b] = o_bit;
      if (o_dd !== (b == 3)) dd_bad++;
      if (b != 3 && o_de) dd_bad++;
      if (b == 3) out_e[d] = o_de;
      if (o_fd) fd_cnt++;
      if (n == NB - 1) fd_last = o_fd;
      if (n == 0) fe_first = o_fe;
    end
    fe_end = o_fe;
  endtask

  task automatic test_reset;
    reset_b = 1'b0;
    bus.in_valid = 1'b0; bus.sync = 1'b0; bus.B_in = 1'b0; bus.mode = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.B_out, bus.out_valid, bus.digit_done, bus.digit_err, bus.frame_done, bus.frame_err} !== 6'b0)
      $display("FAIL reset_outputs got=%b exp=000000",
               {bus.B_out, bus.out_valid, bus.digit_done, bus.digit_err, bus.frame_done, bus.frame_err});
    reset_b = 1'b1;
    step(1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (o_valid !== 1'b0) begin failures++; $display("FAIL idle_no_sync got=%b exp=0", o_valid); end
  endtask

  task automatic test_bcd_to_xs3;
    in_d[0] = 4'd0; in_d[1] = 4'd5; in_d[2] = 4'd9; in_d[3] = 4'd3;
    run_frame(1'b0, NB, 0, 1'b0);
    for (int i = 0; i < ND; i++) begin
      checks++;
      if (out_d[i] !== exp_digit(1'b0, in_d[i])) begin
        failures++; $display("FAIL b2x_digit%0d got=%0d exp=%0d", i, out_d[i], exp_digit(1'b0, in_d[i]));
      end
    end
    checks++;
    if (fd_cnt != 1 || fd_last !== 1'b1) begin
      failures++; $display("FAIL b2x_frame_done got=%0d/%b exp=1/1", fd_cnt, fd_last);
    end
    checks++;
    if (dd_bad != 0 || lat_bad != 0) begin
      failures++; $display("FAIL b2x_beats got=%0d/%0d exp=0/0", dd_bad, lat_bad);
    end
    checks++;
    if (fe_end !== 1'b0) begin failures++; $display("FAIL b2x_frame_err got=%b exp=0", fe_end); end
    for (int j = 0; j < 3; j++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0);
      checks++;
      if (o_valid !== 1'b0) begin failures++; $display("FAIL b2x_idle_ignore got=%b exp=0", o_valid); end
    end
  endtask

  task automatic test_xs3_to_bcd;
    in_d[0] = 4'd3; in_d[1] = 4'd8; in_d[2] = 4'd12; in_d[3] = 4'd6;
    run_frame(1'b1, NB, 0, 1'b0);
    for (int i = 0; i < ND; i++) begin
      checks++;
      if (out_d[i] !== exp_digit(1'b1, in_d[i]) || out_e[i] !== 1'b0) begin
        failures++;
        $display("FAIL x2b_digit%0d got=%0d/err%b exp=%0d/err0", i, out_d[i], out_e[i], exp_digit(1'b1, in_d[i]));
      end
    end
    checks++;
    if (fd_cnt != 1 || dd_bad != 0 || fe_end !== 1'b0) begin
      failures++; $display("FAIL x2b_flags got=fd%0d dd%0d fe%b exp=fd1 dd0 fe0", fd_cnt, dd_bad, fe_end);
    end
  endtask

  task automatic test_invalid;
    in_d[0] = 4'd12; in_d[1] = 4'd4; in_d[2] = 4'd0; in_d[3] = 4'd9;
    run_frame(1'b0, NB, 0, 1'b0);
    checks++;
    if (out_d[0] !== 4'd15 || out_e[0] !== 1'b1) begin
      failures++; $display("FAIL inv_b2x_12 got=%0d/err%b exp=15/err1", out_d[0], out_e[0]);
    end
    checks++;
    if (out_e[1] !== 1'b0 || out_e[2] !== 1'b0 || out_e[3] !== 1'b0 || dd_bad != 0) begin
      failures++; $display("FAIL inv_b2x_others got=%b%b%b dd%0d exp=000 dd0", out_e[1], out_e[2], out_e[3], dd_bad);
    end
    checks++;
    if (fe_end !== 1'b1) begin failures++; $display("FAIL inv_frame_err_set got=%b exp=1", fe_end); end
    for (int j = 0; j < 4; j++) begin
      step(j[0], 1'b0, 1'b0, 1'b0);
      checks++;
      if (o_fe !== 1'b1) begin failures++; $display("FAIL inv_frame_err_sticky got=%b exp=1", o_fe); end
    end
    in_d[0] = 4'd1; in_d[1] = 4'd5; in_d[2] = 4'd7; in_d[3] = 4'd10;
    run_frame(1'b1, NB, 0, 1'b0);
    checks++;
    if (fe_first !== 1'b0) begin failures++; $display("FAIL inv_frame_err_clear got=%b exp=0", fe_first); end
    checks++;
    if (out_d[0] !== 4'd14 || out_e[0] !== 1'b1) begin
      failures++; $display("FAIL inv_x2b_1 got=%0d/err%b exp=14/err1", out_d[0], out_e[0]);
    end
    checks++;
    if (fe_end !== 1'b1) begin failures++; $display("FAIL inv_x2b_frame_err got=%b exp=1", fe_end); end
  endtask

  task automatic test_gaps;
    in_d[0] = 4'd0; in_d[1] = 4'd5; in_d[2] = 4'd9; in_d[3] = 4'd3;
    run_frame(1'b0, NB, 5, 1'b0);
    for (int i = 0; i < ND; i++) begin
      checks++;
      if (out_d[i] !== exp_digit(1'b0, in_d[i])) begin
        failures++; $display("FAIL gap_digit%0d got=%0d exp=%0d", i, out_d[i], exp_digit(1'b0, in_d[i]));
      end
    end
    checks++;
    if (lat_bad != 0 || dd_bad != 0 || fd_cnt != 1 || fd_last !== 1'b1) begin
      failures++; $display("FAIL gap_timing got=lat%0d dd%0d fd%0d exp=lat0 dd0 fd1", lat_bad, dd_bad, fd_cnt);
    end
  endtask

  task automatic test_abort;
    for (int i = 0; i < ND; i++) in_d[i] = 4'($urandom_range(9, 0));
    run_frame(1'b0, 6, 1, 1'b0);
    checks++;
    if (fd_cnt != 0) begin failures++; $display("FAIL abort_no_frame_done got=%0d exp=0", fd_cnt); end
    for (int i = 0; i < ND; i++) in_d[i] = 4'($urandom_range(12, 3));
    run_frame(1'b1, NB, 1, 1'b1);
    for (int i = 0; i < ND; i++) begin
      checks++;
      if (out_d[i] !== exp_digit(1'b1, in_d[i]) || out_e[i] !== 1'b0) begin
        failures++;
        $display("FAIL abort_new_digit%0d got=%0d/err%b exp=%0d/err0", i, out_d[i], out_e[i], exp_digit(1'b1, in_d[i]));
      end
    end
    checks++;
    if (fd_cnt != 1 || fd_last !== 1'b1) begin
      failures++; $display("FAIL abort_new_frame_done got=%0d/%b exp=1/1", fd_cnt, fd_last);
    end
  endtask

  task automatic test_reset_mid;
    in_d[0] = 4'd7; in_d[1] = 4'd1; in_d[2] = 4'd5; in_d[3] = 4'd8;
    run_frame(1'b0, 9, 0, 1'b0);
    reset_b = 1'b0;
    #1;
    checks++;
    if ({bus.B_out, bus.out_valid, bus.digit_done, bus.digit_err, bus.frame_done, bus.frame_err} !== 6'b0) begin
      failures++; $display("FAIL rst_mid_async got=%b exp=000000",
        {bus.B_out, bus.out_valid, bus.digit_done, bus.digit_err, bus.frame_done, bus.frame_err});
    end
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      step(1'b1, j == 0, 1'b1, 1'b0);
      checks++;
      if ({o_bit, o_valid, o_dd, o_de, o_fd, o_fe} !== 6'b0) begin
        failures++; $display("FAIL rst_mid_hold got=%b exp=000000", {o_bit, o_valid, o_dd, o_de, o_fd, o_fe});
      end
    end
    reset_b = 1'b1;
    in_d[0] = 4'd9; in_d[1] = 4'd2; in_d[2] = 4'd6; in_d[3] = 4'd4;
    run_frame(1'b0, NB, 0, 1'b0);
    for (int i = 0; i < ND; i++) begin
      checks++;
      if (out_d[i] !== exp_digit(1'b0, in_d[i])) begin
        failures++; $display("FAIL rst_mid_digit%0d got=%0d exp=%0d", i, out_d[i], exp_digit(1'b0, in_d[i]));
      end
    end
    checks++;
    if (fd_cnt != 1 || fe_end !== 1'b0) begin
      failures++; $display("FAIL rst_mid_flags got=fd%0d fe%b exp=fd1 fe0", fd_cnt, fe_end);
    end
  endtask

  task automatic test_random;
    logic m;
    logic any_err;
    for (int f = 0; f < 25; f++) begin
      m = 1'($urandom);
      any_err = 1'b0;
      for (int i = 0; i < ND; i++) begin
        in_d[i] = 4'($urandom_range(15, 0));
        any_err |= exp_err(m, in_d[i]);
      end
      run_frame(m, NB, 2, 1'b1);
      for (int i = 0; i < ND; i++) begin
        checks++;
        if (out_d[i] !== exp_digit(m, in_d[i]) || out_e[i] !== exp_err(m, in_d[i])) begin
          failures++;
          $display("FAIL rand_f%0d_d%0d m=%b in=%0d got=%0d/err%b exp=%0d/err%b", f, i, m, in_d[i],
                   out_d[i], out_e[i], exp_digit(m, in_d[i]), exp_err(m, in_d[i]));
        end
      end
      checks++;
      if (fd_cnt != 1 || fd_last !== 1'b1 || lat_bad != 0 || dd_bad != 0 || fe_end !== any_err) begin
        failures++;
        $display("FAIL rand_f%0d_flags got=fd%0d lat%0d dd%0d fe%b exp=fd1 lat0 dd0 fe%b",
                 f, fd_cnt, lat_bad, dd_bad, fe_end, any_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bcd_to_xs3();
    test_xs3_to_bcd();
    test_invalid();
    test_gaps();
    test_abort();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
